// File: rtl/z80_console_fifo.sv
// Buffered console channel: Z80 OUTs fill a TX FIFO drained by the RISC-V,
// RISC-V writes fill an RX FIFO consumed by Z80 INs; the Z80 waits only when its FIFO cannot serve it.
module z80_console_fifo #(
    parameter int          DEPTH_LOG2 = 4,
    parameter logic [7:0]  STAT_PORT  = 8'h00,
    parameter logic [7:0]  DATA_PORT  = 8'h01
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       z80_iord,
    input  logic       z80_iowr,
    input  logic [7:0] z80adr,
    input  logic [7:0] z80do,
    output logic [7:0] z80di,
    output logic       z80_io_ready,
    output logic       z80_io_hit,
    input  logic       io_valid,
    input  logic [3:0] rv_adr,
    input  logic [7:0] rv_wdata,
    input  logic       rv_wstr,
    output logic [7:0] rv_rdata,
    output logic       irq,
    output logic [1:0] dbg_state
);

    localparam int CW = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STALL  = 2'd1,
        ACTIVE = 2'd2
    } z_state_t;

    z_state_t state;
    z_state_t state_next;

    // TX FIFO: Z80 -> RISC-V
    logic [7:0]            tx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] tx_wptr;
    logic [DEPTH_LOG2-1:0] tx_rptr;
    logic [CW-1:0]         tx_count;
    logic                  tx_full;
    logic                  tx_empty;
    logic                  tx_push;
    logic                  tx_pop;

    // RX FIFO: RISC-V -> Z80
    logic [7:0]            rx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rx_wptr;
    logic [DEPTH_LOG2-1:0] rx_rptr;
    logic [CW-1:0]         rx_count;
    logic                  rx_full;
    logic                  rx_empty;
    logic                  rx_push;
    logic                  rx_pop;
    logic                  rx_drop;

    logic strobe;
    logic is_stat;
    logic is_data;
    logic blocked;
    logic take;
    logic acc_data_rd;

    logic io_valid_d;
    logic rv_fire;
    logic rv_rd;
    logic rv_wr;
    logic stat_rd;
    logic overflow;
    logic irq_en;

    assign tx_full  = (tx_count == DEPTH_C);
    assign tx_empty = (tx_count == '0);
    assign rx_full  = (rx_count == DEPTH_C);
    assign rx_empty = (rx_count == '0);

    // ---------------- Z80 side decode ----------------
    assign strobe     = z80_iord | z80_iowr;
    assign is_stat    = (z80adr == STAT_PORT);
    assign is_data    = (z80adr == DATA_PORT);
    assign z80_io_hit = strobe && (is_stat || is_data);

    // A TX pop landing this cycle frees the slot the stalled write needs.
    assign blocked = strobe && is_data &&
                     ((z80_iowr && tx_full && !tx_pop) || (z80_iord && rx_empty));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (z80_io_hit) begin
                    state_next = blocked ? STALL : ACTIVE;
                end
            end
            STALL: begin
                if (!strobe) begin
                    state_next = IDLE;
                end else if (!blocked) begin
                    state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                if (!strobe) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        take         = 1'b0;
        tx_push      = 1'b0;
        rx_pop       = 1'b0;
        z80_io_ready = 1'b1;
        case (state)
            IDLE: begin
                take         = z80_io_hit && !blocked;
                tx_push      = take && z80_iowr && is_data;
                z80_io_ready = !blocked;
            end
            STALL: begin
                take         = strobe && !blocked;
                tx_push      = take && z80_iowr && is_data;
                z80_io_ready = 1'b0;
            end
            ACTIVE: begin
                rx_pop = !strobe && acc_data_rd && !rx_empty;
            end
            default: ;
        endcase
    end

    assign dbg_state = state;

    // Remembers whether the access in flight must consume an RX byte when it ends.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc_data_rd <= 1'b0;
        end else if (take) begin
            acc_data_rd <= z80_iord && is_data;
        end
    end

    always_comb begin
        if (is_stat) begin
            z80di = {6'b0, !tx_full, !rx_empty};
        end else if (is_data) begin
            z80di = rx_mem[rx_rptr];
        end else begin
            z80di = 8'hFF;
        end
    end

    // ---------------- RISC-V side ----------------
    assign rv_fire = io_valid && !io_valid_d;
    assign rv_rd   = rv_fire && !rv_wstr;
    assign rv_wr   = rv_fire && rv_wstr;
    assign tx_pop  = rv_rd && (rv_adr == 4'd0) && !tx_empty;
    assign rx_push = rv_wr && (rv_adr == 4'd2) && !rx_full;
    assign rx_drop = rv_wr && (rv_adr == 4'd2) && rx_full;
    assign stat_rd = rv_rd && (rv_adr == 4'd3);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            io_valid_d <= 1'b0;
            overflow   <= 1'b0;
            irq_en     <= 1'b0;
            irq        <= 1'b0;
            rv_rdata   <= 8'h00;
        end else begin
            io_valid_d <= io_valid;
            irq        <= irq_en && !tx_empty;
            if (rx_drop) begin
                overflow <= 1'b1;
            end else if (stat_rd) begin
                overflow <= 1'b0;
            end
            if (rv_wr && (rv_adr == 4'd4)) begin
                irq_en <= rv_wdata[0];
            end
            if (rv_rd) begin
                case (rv_adr)
                    4'd0:    rv_rdata <= tx_empty ? 8'h00 : tx_mem[tx_rptr];
                    4'd1:    rv_rdata <= {7'(tx_count), !tx_empty};
                    4'd3:    rv_rdata <= {5'b0, overflow, rx_full, rx_empty};
                    4'd4:    rv_rdata <= {7'b0, irq_en};
                    default: rv_rdata <= 8'h00;
                endcase
            end
        end
    end

    // ---------------- FIFO storage and pointers ----------------
    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wptr] <= z80do;
        end
        if (rx_push) begin
            rx_mem[rx_wptr] <= rv_wdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_count <= '0;
            rx_wptr  <= '0;
            rx_rptr  <= '0;
            rx_count <= '0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + 1'b1;
            if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
            if (rx_push) rx_wptr <= rx_wptr + 1'b1;
            if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
            tx_count <= tx_count + CW'(tx_push) - CW'(tx_pop);
            rx_count <= rx_count + CW'(rx_push) - CW'(rx_pop);
        end
    end

endmodule

// File: tb/tb_z80_console_fifo.sv
// Bench for z80_console_fifo: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized concurrent traffic.
module tb_z80_console_fifo;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       z80_iord = 1'b0;
    logic       z80_iowr = 1'b0;
    logic [7:0] z80adr = 8'h00;
    logic [7:0] z80do = 8'h00;
    logic [7:0] z80di;
    logic       z80_io_ready;
    logic       z80_io_hit;
    logic       io_valid = 1'b0;
    logic [3:0] rv_adr = 4'h0;
    logic [7:0] rv_wdata = 8'h00;
    logic       rv_wstr = 1'b0;
    logic [7:0] rv_rdata;
    logic       irq;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    z80_console_fifo dut (
        .clk          (clk),
        .resetn       (resetn),
        .z80_iord     (z80_iord),
        .z80_iowr     (z80_iowr),
        .z80adr       (z80adr),
        .z80do        (z80do),
        .z80di        (z80di),
        .z80_io_ready (z80_io_ready),
        .z80_io_hit   (z80_io_hit),
        .io_valid     (io_valid),
        .rv_adr       (rv_adr),
        .rv_wdata     (rv_wdata),
        .rv_wstr      (rv_wstr),
        .rv_rdata     (rv_rdata),
        .irq          (irq),
        .dbg_state    (dbg_state)
    );

    int n_checks = 0;
    int n_fail = 0;
    bit chk_en = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    bit         m_ovf = 0;
    bit         m_irq_en = 0;
    bit         m_irq = 0;
    bit         m_valid_d = 0;
    bit         m_acted = 0;
    bit         m_stalled = 0;
    bit         m_rdpop = 0;
    logic [7:0] m_rdata = 8'h00;

    function automatic bit z_blocked();
        bit fire;
        bit pop;
        fire = io_valid && !m_valid_d;
        pop  = fire && !rv_wstr && (rv_adr == 4'd0) && (tx_q.size() > 0);
        return (z80_iord || z80_iowr) && (z80adr == 8'h01) &&
               ((z80_iowr && tx_q.size() == 16 && !pop) || (z80_iord && rx_q.size() == 0));
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_q.delete();
            rx_q.delete();
            m_ovf = 0; m_irq_en = 0; m_irq = 0; m_valid_d = 0;
            m_acted = 0; m_stalled = 0; m_rdpop = 0; m_rdata = 8'h00;
        end else begin : model_step
            bit strobe, hit, fire, blk, tx_pop, rx_push, rx_drop, z_push, z_pop;
            logic [7:0] z_byte;
            int txn, rxn;
            txn = tx_q.size();
            rxn = rx_q.size();
            strobe = z80_iord || z80_iowr;
            hit = strobe && (z80adr == 8'h00 || z80adr == 8'h01);
            fire = io_valid && !m_valid_d;
            blk = z_blocked();
            tx_pop = fire && !rv_wstr && rv_adr == 4'd0 && txn > 0;
            rx_push = fire && rv_wstr && rv_adr == 4'd2 && rxn < 16;
            rx_drop = fire && rv_wstr && rv_adr == 4'd2 && rxn == 16;
            z_push = 0; z_pop = 0; z_byte = z80do;
            if (!strobe) begin
                z_pop = m_acted && m_rdpop;
                m_acted = 0; m_stalled = 0; m_rdpop = 0;
            end else if (hit && !m_acted) begin
                if (blk) begin
                    m_stalled = 1;
                end else begin
                    m_stalled = 0;
                    m_acted = 1;
                    z_push = z80_iowr && z80adr == 8'h01;
                    m_rdpop = z80_iord && z80adr == 8'h01;
                end
            end
            if (fire && !rv_wstr) begin
                case (rv_adr)
                    4'd0:    m_rdata = (txn > 0) ? tx_q[0] : 8'h00;
                    4'd1:    m_rdata = {txn[6:0], txn > 0};
                    4'd3:    m_rdata = {5'b0, m_ovf, rxn == 16, rxn == 0};
                    4'd4:    m_rdata = {7'b0, m_irq_en};
                    default: m_rdata = 8'h00;
                endcase
            end
            m_irq = m_irq_en && txn > 0;
            if (fire && rv_wstr && rv_adr == 4'd4) m_irq_en = rv_wdata[0];
            if (rx_drop) m_ovf = 1;
            else if (fire && !rv_wstr && rv_adr == 4'd3) m_ovf = 0;
            if (tx_pop) void'(tx_q.pop_front());
            if (z_push) tx_q.push_back(z_byte);
            if (z_pop) void'(rx_q.pop_front());
            if (rx_push) rx_q.push_back(rv_wdata);
            m_valid_d = io_valid;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin : cmp
            bit strobe, hit, exp_ready;
            strobe = z80_iord || z80_iowr;
            hit = strobe && (z80adr == 8'h00 || z80adr == 8'h01);
            exp_ready = !(m_stalled || (hit && !m_acted && z_blocked()));
            check("ready", {7'b0, z80_io_ready}, {7'b0, exp_ready});
            check("hit", {7'b0, z80_io_hit}, {7'b0, hit});
            check("irq", {7'b0, irq}, {7'b0, m_irq});
            check("rv_rdata", rv_rdata, m_rdata);
            check("dbg_state_legal", {7'b0, dbg_state == 2'd3}, 8'h00);
            if (z80adr == 8'h00) begin
                check("z80di_stat", z80di, {6'b0, tx_q.size() < 16, rx_q.size() > 0});
            end else if (z80adr == 8'h01) begin
                if (rx_q.size() > 0) check("z80di_data", z80di, rx_q[0]);
            end else begin
                check("z80di_other", z80di, 8'hFF);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic wait_ready(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!z80_io_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, {7'b0, z80_io_ready}, 8'h01);
    endtask

    task automatic z80_out(input logic [7:0] p, input logic [7:0] d, input int hold);
        z80adr = p;
        z80do = d;
        z80_iowr = 1'b1;
        wait_ready("out_ready_timeout");
        repeat (hold) @(posedge clk);
        #1;
        z80_iowr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic z80_in(input logic [7:0] p, input int hold, output logic [7:0] q);
        z80adr = p;
        z80_iord = 1'b1;
        wait_ready("in_ready_timeout");
        q = z80di;
        repeat (hold) @(posedge clk);
        #1;
        z80_iord = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic rv_access(input logic [3:0] a, input logic w, input logic [7:0] d,
                             input int hold, output logic [7:0] q);
        io_valid = 1'b1;
        rv_adr = a;
        rv_wstr = w;
        rv_wdata = d;
        @(posedge clk);
        #1;
        q = rv_rdata;
        repeat (hold - 1) begin
            @(posedge clk);
            #1;
        end
        io_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- scenarios ----------------
    initial begin : main
        logic [7:0] q, q2;
        int zop, radr, rhold, zhold, zdly, rdly;
        logic rw;
        logic [7:0] zp;

        @(posedge clk);
        #1;
        chk_en = 1;
        @(negedge clk);
        check("reset_rdata", rv_rdata, 8'h00);
        check("reset_ready", {7'b0, z80_io_ready}, 8'h01);
        check("reset_irq", {7'b0, irq}, 8'h00);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Status read right after reset
        z80_in(8'h00, 1, q);
        check("stat_after_reset", q, 8'h02);
        rv_access(4'd1, 1'b0, 8'h00, 1, q);
        check("txstat_reset", q, 8'h00);

        // Two OUTs with long strobes push exactly once each
        z80_out(8'h01, 8'h48, 4);
        z80_out(8'h01, 8'h69, 4);
        rv_access(4'd1, 1'b0, 8'h00, 2, q);
        check("txstat_two", q, 8'h05);
        rv_access(4'd0, 1'b0, 8'h00, 3, q);
        check("txdata_H", q, 8'h48);
        rv_access(4'd0, 1'b0, 8'h00, 1, q);
        check("txdata_i", q, 8'h69);
        rv_access(4'd1, 1'b0, 8'h00, 1, q);
        check("txstat_drained", q, 8'h00);

        // Fill TX, the 17th OUT stalls until the RISC-V pops
        for (int i = 0; i < 16; i++) z80_out(8'h01, 8'h30 + 8'(i), 1);
        fork
            z80_out(8'h01, 8'h40, 2);
            begin
                repeat (4) @(posedge clk);
                @(negedge clk);
                check("stall17_ready", {7'b0, z80_io_ready}, 8'h00);
                @(posedge clk);
                #1;
                rv_access(4'd0, 1'b0, 8'h00, 1, q2);
                check("tx_first_pop", q2, 8'h30);
            end
        join
        rv_access(4'd1, 1'b0, 8'h00, 1, q);
        check("txstat_full", q, 8'h21);
        for (int i = 1; i < 16; i++) begin
            rv_access(4'd0, 1'b0, 8'h00, 1, q);
            check("tx_drain", q, 8'h30 + 8'(i));
        end
        rv_access(4'd0, 1'b0, 8'h00, 1, q);
        check("tx_last_17th", q, 8'h40);
        rv_access(4'd0, 1'b0, 8'h00, 1, q);
        check("txdata_empty", q, 8'h00);

        // IN on empty RX stalls until the RISC-V pushes
        fork
            z80_in(8'h01, 2, q);
            begin
                repeat (4) @(posedge clk);
                @(negedge clk);
                check("rx_stall_ready", {7'b0, z80_io_ready}, 8'h00);
                @(posedge clk);
                #1;
                rv_access(4'd2, 1'b1, 8'h41, 1, q2);
            end
        join
        check("rx_stalled_read", q, 8'h41);
        rv_access(4'd3, 1'b0, 8'h00, 1, q);
        check("rxstat_after_read", q, 8'h01);

        // RX overflow: 17 writes, sticky flag cleared by status read
        for (int i = 0; i < 17; i++) rv_access(4'd2, 1'b1, 8'h60 + 8'(i), 1, q);
        rv_access(4'd3, 1'b0, 8'h00, 1, q);
        check("rxstat_ovf", q, 8'h06);
        rv_access(4'd3, 1'b0, 8'h00, 1, q);
        check("rxstat_ovf_cleared", q, 8'h02);
        for (int i = 0; i < 16; i++) begin
            z80_in(8'h01, 1, q);
            check("rx_order", q, 8'h60 + 8'(i));
        end
        rv_access(4'd3, 1'b0, 8'h00, 1, q);
        check("rxstat_empty", q, 8'h01);

        // Interrupt follows TX non-empty when enabled
        rv_access(4'd4, 1'b1, 8'h01, 1, q);
        rv_access(4'd4, 1'b0, 8'h00, 1, q);
        check("irqen_read", q, 8'h01);
        z80_out(8'h01, 8'h0D, 2);
        @(negedge clk);
        check("irq_set", {7'b0, irq}, 8'h01);
        @(posedge clk);
        #1;
        rv_access(4'd0, 1'b0, 8'h00, 1, q);
        check("irq_byte", q, 8'h0D);
        @(negedge clk);
        check("irq_clear", {7'b0, irq}, 8'h00);
        @(posedge clk);
        #1;

        // Randomized concurrent traffic
        for (int it = 0; it < 300; it++) begin
            zop = $urandom_range(0, 6);
            radr = $urandom_range(0, 7);
            rw = 1'($urandom_range(0, 1));
            rhold = $urandom_range(1, 3);
            zhold = $urandom_range(1, 4);
            zdly = $urandom_range(0, 2);
            rdly = $urandom_range(0, 3);
            if (zop >= 2 && zop <= 3 && rx_q.size() == 0) begin
                radr = 2; rw = 1'b1;
            end
            if (zop <= 1 && tx_q.size() == 16) begin
                radr = 0; rw = 1'b0;
            end
            case (zop)
                4:       zp = 8'h00;
                5:       zp = 8'h05;
                6:       zp = 8'h80;
                default: zp = 8'h01;
            endcase
            fork
                begin
                    repeat (zdly) begin @(posedge clk); #1; end
                    if (zop <= 1 || zop == 6) z80_out(zp, 8'($urandom_range(0, 255)), zhold);
                    else z80_in(zp, zhold, q);
                end
                begin
                    repeat (rdly) begin @(posedge clk); #1; end
                    rv_access(4'(radr), rw, 8'($urandom_range(0, 255)), rhold, q2);
                end
            join
        end

        // Asynchronous reset while the Z80 is stalled
        while (rx_q.size() > 0) z80_in(8'h01, 1, q);
        if (tx_q.size() < 2) z80_out(8'h01, 8'h55, 1);
        rv_access(4'd1, 1'b0, 8'h00, 1, q);
        z80adr = 8'h01;
        z80_iord = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pre_reset_stall", {7'b0, z80_io_ready}, 8'h00);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        z80_iord = 1'b0;
        z80adr = 8'h00;
        #1;
        check("async_reset_ready", {7'b0, z80_io_ready}, 8'h01);
        check("async_reset_stat", z80di, 8'h02);
        check("async_reset_rdata", rv_rdata, 8'h00);
        check("async_reset_irq", {7'b0, irq}, 8'h00);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        rv_access(4'd1, 1'b0, 8'h00, 1, q);
        check("txstat_after_reset", q, 8'h00);
        rv_access(4'd4, 1'b0, 8'h00, 1, q);
        check("irqen_after_reset", q, 8'h00);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
